div_seq_arb: RTL and testbench
==============================

DIV_SEQ_ARB -- requirements
Module: div_seq_arb

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  requester 0/1 division request, level, held until granted.
REQ-005 SHALL have ports a0/a1  input  W  dividend of requester 0/1, valid while reqN high.
REQ-006 SHALL have ports b0/b1  input  W  divisor of requester 0/1, valid while reqN high.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle grant; operands captured in that cycle.
REQ-008 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse: q/r/id/dbz valid.
REQ-010 SHALL have ports q, r  output  W  quotient, remainder.
REQ-011 SHALL have port id  output  1  requester index owning the current result.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; a single shared unsigned restoring divider resolves one quotient bit per CALC cycle.
REQ-014 IDLE: if either reqN high, SHALL assert exactly one gntN for one cycle, latch aN/bN and the index, and transition to CALC (bN != 0) or DONE (bN == 0).
REQ-015 gnt0/gnt1 SHALL never both be high and SHALL be low outside IDLE; requests arriving in CALC/DONE wait, and are never dropped.
REQ-016 Arbitration: both requests high -> grant the requester not granted last; single request -> grant it.
REQ-017 CALC: bit counter starts at W-1; each cycle partial remainder P = {P, A[i]}; if P >= B then P = P - B and Q[i] = 1, else Q[i] = 0; after the i = 0 cycle transition to DONE.
REQ-018 Partial remainder SHALL be held at W+1 bits so that no shift overflows for any B up to 2^W-1.
REQ-019 DONE: done = 1 for exactly one cycle, then IDLE; q, r, id, dbz update on the DONE entry edge and hold until the next DONE.
REQ-020 Latency: gnt in cycle T -> done in cycle T+W+1 (T+5 for W=4); divide-by-zero -> done in T+1.
REQ-021 Divide-by-zero SHALL give q = 0, r = 0, dbz = 1; otherwise dbz = 0.
REQ-022 Minimum issue spacing between grants SHALL be W+2 cycles (normal) or 2 cycles (divide-by-zero).
REQ-023 Operand changes on aN/bN after the grant cycle SHALL NOT affect the result in flight.

Reset
REQ-024 rst high SHALL force IDLE, gnt0 = gnt1 = 0, busy = 0, done = 0, q = 0, r = 0, id = 0, dbz = 0 on the next edge.
REQ-025 Reset SHALL clear the round-robin pointer so that requester 0 wins the first contended grant.
REQ-026 Reset in CALC or DONE SHALL abort the operation with no done pulse; the aborted request is not retried.

Configuration
REQ-027 Macro DIV_SEQ_ARB_RR_EN defined: arbitration SHALL be round-robin per REQ-016/REQ-025.
REQ-028 DIV_SEQ_ARB_RR_EN undefined: fixed priority SHALL apply, with req0 always winning over req1; no pointer state.

Verification
REQ-029 Bench SHALL cover: req0 only, a0=13, b0=4, W=4 -> gnt0 at T, done at T+5, q=3, r=1, id=0, dbz=0.
REQ-030 Bench SHALL cover: req1 only, a1=7, b1=0 -> gnt1 at T, done at T+1, q=0, r=0, id=1, dbz=1.
REQ-031 Bench SHALL cover: req0 and req1 held high from reset, 15/2 and 9/9 -> RR_EN: grants alternate 0,1,0,1 with results q=7/r=1 and q=1/r=0; no RR_EN: gnt0 every issue, gnt1 never.
REQ-032 Bench SHALL cover: a0=15, b0=9 (overflow-prone divisor) -> q=1, r=6.
REQ-033 Bench SHALL cover: rst asserted 2 cycles after gnt0 -> no done pulse, all outputs 0, next req1 granted normally with correct result.
REQ-034 Bench SHALL cover: an exhaustive sweep of all a, b in 0..15 -> q = a/b and r = a%b for b != 0, dbz set exactly when b = 0.

Source files
------------

// File: rtl/div_seq_arb.sv
// div_seq_arb: two-requester arbiter in front of one shared sequential
// unsigned restoring divider (one quotient bit per CALC cycle).
// Optional build macro DIV_SEQ_ARB_RR_EN selects round-robin arbitration.
// Without it, fixed priority applies: req0 always wins.
module div_seq_arb #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         id,
    output logic         dbz
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic         pick1;      // arbitration winner is requester 1
    logic         take;       // a grant is issued this cycle
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          id_reg;
    logic [W-1:0]  q_work;
    logic [W-1:0]  q_next;
    logic [W:0]    p;         // partial remainder, one guard bit above W
    logic [W:0]    p_shift;
    logic [W:0]    p_next;
    logic          ge;
    logic [CW-1:0] cnt;

`ifdef DIV_SEQ_ARB_RR_EN
    logic rr_ptr;             // 1: requester 1 wins the next contended grant

    // Round-robin winner: a tie goes to whoever was not granted last
    always_comb begin
        pick1 = req1 && (!req0 || rr_ptr);
    end

    // Pointer flips to the requester that lost the grant just issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (take) begin
            rr_ptr <= ~pick1;
        end
    end
`else
    // Fixed priority winner: requester 0 always wins
    always_comb begin
        pick1 = req1 && !req0;
    end
`endif

    // Operand mux for the winning requester
    always_comb begin
        sel_a = pick1 ? a1 : a0;
        sel_b = pick1 ? b1 : b0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, grant and status decode
    always_comb begin
        state_next = state;
        take       = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                // grants are suppressed while reset is held so none is lost
                if (!rst && (req0 || req1)) begin
                    take       = 1'b1;
                    gnt0       = !pick1;
                    gnt1       = pick1;
                    state_next = (sel_b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract
    always_comb begin
        p_shift = (p << 1) | {{W{1'b0}}, a_reg[cnt]};
        ge      = (p_shift >= {1'b0, b_reg});
        p_next  = ge ? (p_shift - {1'b0, b_reg}) : p_shift;
        q_next      = q_work;
        q_next[cnt] = ge;
    end

    // Operand capture, iteration state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            id_reg <= 1'b0;
            q_work <= '0;
            p      <= '0;
            cnt    <= '0;
            q      <= '0;
            r      <= '0;
            id     <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        id_reg <= pick1;
                        q_work <= '0;
                        p      <= '0;
                        cnt    <= CW'(W - 1);
                        if (sel_b == '0) begin
                            q   <= '0;
                            r   <= '0;
                            id  <= pick1;
                            dbz <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    p      <= p_next;
                    q_work <= q_next;
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0) begin
                        q   <= q_next;
                        r   <= p_next[W-1:0];
                        id  <= id_reg;
                        dbz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_arb.sv
// tb_div_seq_arb: scoreboard bench for div_seq_arb (W = 4).
// Stimulus pushes expected results at grant time; a negedge monitor pops
// and compares on every done pulse.
module tb_div_seq_arb;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         id;
    logic         dbz;

    div_seq_arb #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .a0   (a0),
        .b0   (b0),
        .a1   (a1),
        .b1   (b1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .id   (id),
        .dbz  (dbz)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           t_gnt;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant sanity every cycle, result compare on each done pulse
    always @(negedge clk) begin
        exp_t e;
        if (gnt0 || gnt1) begin
            chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        end
        if (busy) begin
            chk("gnt_outside_idle", 32'(gnt0 | gnt1), 32'd0);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res_id",  32'(id),  32'(e.id));
                chk("res_q",   32'(q),   32'(e.q));
                chk("res_r",   32'(r),   32'(e.r));
                chk("res_dbz", 32'(dbz), 32'(e.dbz));
                chk("latency", 32'(cyc - e.t_gnt), 32'(e.lat));
            end
        end
    end

    task automatic push_exp(input logic who, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edbz);
        exp_t e;
        e.id    = who;
        e.q     = eq;
        e.r     = er;
        e.dbz   = edbz;
        e.t_gnt = cyc;
        e.lat   = edbz ? 1 : W + 1;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: no grant within 40 cycles, a grant was required");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d busy=%0d, required 0 and 0", sb.size(), busy);
        end
    endtask

    // Single uncontended request; operands are scrambled right after the grant
    task automatic do_op(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        bit ok;
        @(posedge clk);
        #1;
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        wait_gnt(ok);
        if (ok) begin
            chk("gnt_who", 32'(gnt1), 32'(who));
            push_exp(who, eq, er, edbz);
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = W'($urandom); b0 = W'($urandom);
        a1 = W'($urandom); b1 = W'($urandom);
        wait_idle();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_gnt"},  32'({gnt0, gnt1}), 32'd0);
        chk({tag, "_q"},    32'(q), 32'd0);
        chk({tag, "_r"},    32'(r), 32'd0);
        chk({tag, "_id"},   32'(id), 32'd0);
        chk({tag, "_dbz"},  32'(dbz), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int prev_t;
        logic who;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset");

        // Directed single-requester vectors
        do_op(1'b0, 4'd13, 4'd4,  4'd3, 4'd1, 1'b0);
        do_op(1'b1, 4'd7,  4'd0,  4'd0, 4'd0, 1'b1);
        do_op(1'b0, 4'd15, 4'd9,  4'd1, 4'd6, 1'b0);
        do_op(1'b1, 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        do_op(1'b0, 4'd0,  4'd7,  4'd0, 4'd0, 1'b0);
        do_op(1'b0, 4'd15, 4'd1,  4'd15, 4'd0, 1'b0);
        do_op(1'b1, 4'd11, 4'd3,  4'd3, 4'd2, 1'b0);

        // Reset two cycles after a grant aborts the operation silently
        @(posedge clk);
        #1;
        req0 = 1'b1; a0 = 4'd13; b0 = 4'd4;
        wait_gnt(ok);
        if (ok) chk("abort_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("abort");
        repeat (8) @(negedge clk);
        chk("abort_no_pending", 32'(sb.size()), 32'd0);
        do_op(1'b1, 4'd7, 4'd3, 4'd2, 4'd1, 1'b0);

        // Both requests held high from reset
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd2;
        req1 = 1'b1; a1 = 4'd9;  b1 = 4'd9;
        @(negedge clk);
        chk("rst_gnt_blocked", 32'({gnt0, gnt1}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_t = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(ok);
            if (!ok) break;
`ifdef DIV_SEQ_ARB_RR_EN
            who = (k % 2 == 1);
`else
            who = 1'b0;
`endif
            chk("contend_order", 32'(gnt1), 32'(who));
            if (k > 0) chk("issue_spacing", 32'(cyc - prev_t), 32'(W + 2));
            prev_t = cyc;
            if (who) push_exp(1'b1, 4'd1, 4'd0, 1'b0);
            else     push_exp(1'b0, 4'd7, 4'd1, 1'b0);
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();

        // Exhaustive operand sweep, requester alternating
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) do_op(1'((a + b) % 2), W'(a), W'(b), '0, '0, 1'b1);
                else        do_op(1'((a + b) % 2), W'(a), W'(b), W'(a / b), W'(a % b), 1'b0);
            end
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
